mod503_residue_acc: RTL and testbench



---
 rtl/mod503_pkg.sv | 22 ++
 rtl/mod503_add.sv | 25 ++
 rtl/mod503_residue_acc.sv | 112 +++++++++++
 tb/tb_mod503_residue_acc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mod503_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod503_pkg
// Brief    : Shared constants, residue type and FSM state encoding for the
//            mod-503 residue accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package mod503_pkg;

    localparam int MOD_P = 503;
    localparam int RES_W = 9;

    typedef logic [RES_W-1:0] residue_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mod503_add.sv
`default_nettype none
// ============================================================================
// Module   : mod503_add
// Brief    : Combinational modular adder, y = (a + b) mod MOD for a, b < MOD.
// Revision : 1.0 - initial release
// ============================================================================
module mod503_add #(
    parameter int MOD = 503,
    parameter int W   = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    localparam logic [W:0] c_mod = (W+1)'(MOD);

    // One extra bit keeps the carry so a single conditional subtract suffices.
    logic [W:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum = (w_sum >= c_mod) ? W'(w_sum - c_mod) : w_sum[W-1:0];

endmodule
`default_nettype wire

// File: rtl/mod503_residue_acc.sv
`default_nettype none
// ============================================================================
// Module   : mod503_residue_acc
// Brief    : Packet-wise residue accumulator: sums normalised residues mod MOD,
//            counts terms (saturating) and flags out-of-range inputs.
// Revision : 1.0 - initial release
// ============================================================================
module mod503_residue_acc #(
    parameter int MOD   = mod503_pkg::MOD_P,
    parameter int RES_W = mod503_pkg::RES_W,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_res,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_res,
    output logic [CNT_W-1:0] out_terms,
    output logic             out_err
);

    import mod503_pkg::state_t;
    import mod503_pkg::IDLE;
    import mod503_pkg::ACC;
    import mod503_pkg::DONE;

    localparam logic [RES_W-1:0] c_mod     = RES_W'(MOD);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state;
    logic [RES_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic             w_accept;
    logic             w_take;
    logic             w_over;
    logic [RES_W-1:0] w_norm;
    logic [RES_W-1:0] w_base_acc;
    logic [CNT_W-1:0] w_base_cnt;
    logic             w_base_err;
    logic [RES_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_err_next;

    assign in_ready = (r_state != DONE) || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_take   = out_valid && out_ready;

    // Inputs never exceed 2*MOD-1, so one subtraction fully normalises them.
    assign w_over = (in_res >= c_mod);
    assign w_norm = w_over ? (in_res - c_mod) : in_res;

    // A beat accepted in DONE coincides with a take and opens a fresh packet.
    assign w_base_acc = (r_state == DONE) ? '0   : r_acc;
    assign w_base_cnt = (r_state == DONE) ? '0   : r_cnt;
    assign w_base_err = (r_state == DONE) ? 1'b0 : r_err;

    assign w_cnt_next = (w_base_cnt == c_cnt_max) ? w_base_cnt : w_base_cnt + CNT_W'(1);
    assign w_err_next = w_base_err || w_over;

    mod503_add #(
        .MOD (MOD),
        .W   (RES_W)
    ) u_add (
        .i_a   (w_base_acc),
        .i_b   (w_norm),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_terms <= '0;
            out_err   <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_state   <= DONE;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_err     <= 1'b0;
                out_valid <= 1'b1;
                out_res   <= w_sum;
                out_terms <= w_cnt_next;
                out_err   <= w_err_next;
            end else begin
                r_state   <= ACC;
                r_acc     <= w_sum;
                r_cnt     <= w_cnt_next;
                r_err     <= w_err_next;
                out_valid <= 1'b0;
            end
        end else if (w_take) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod503_residue_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod503_residue_acc
// Brief    : Directed self-checking bench for mod503_residue_acc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod503_residue_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_res;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_res;
    logic [4:0] out_terms;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod503_residue_acc #(
        .MOD   (503),
        .RES_W (9),
        .CNT_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_terms (out_terms),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input int v, input logic last);
        in_valid = 1'b1;
        in_res   = 9'(v);
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input int res, input int terms, input int err);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_res"},   int'(out_res),   res);
        check({tag, "_terms"}, int'(out_terms), terms);
        check({tag, "_err"},   int'(out_err),   err);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_res    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_res",   int'(out_res),   0);
        check("rst_terms", int'(out_terms), 0);
        check("rst_err",   int'(out_err),   0);
        rst_n = 1'b1;
        check("rst_in_ready", int'(in_ready), 1);

        // 502 + 1 wraps to exactly zero
        beat(502, 1'b0);
        check("t1_mid_valid", int'(out_valid), 0);
        beat(1, 1'b1);
        check_result("t1", 0, 2, 0);
        take();
        check("t1_taken_valid", int'(out_valid), 0);
        check("t1_taken_ready", int'(in_ready), 1);

        // 500+500 = 497, 497+500 = 494
        beat(500, 1'b0);
        beat(500, 1'b0);
        beat(500, 1'b1);
        check_result("t2", 494, 3, 0);
        take();

        // out-of-range 510 normalises to 7 and flags the packet
        beat(510, 1'b1);
        check_result("t3a", 7, 1, 1);
        take();
        beat(5, 1'b1);
        check_result("t3b", 5, 1, 0);
        take();

        // stalled result; a pending beat must be held off while stalled
        beat(250, 1'b1);
        in_valid = 1'b1;
        in_res   = 9'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_res",   int'(out_res),   250);
            check("t4_stall_valid", int'(out_valid), 1);
            check("t4_stall_ready", int'(in_ready),  0);
            @(posedge clk);
            #1;
        end
        check_result("t4_held", 250, 1, 0);
        in_res    = 9'd100;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check_result("t4_next", 100, 1, 0);
        take();
        check("t4_taken_valid", int'(out_valid), 0);

        // reset mid-packet discards the partial sum
        beat(400, 1'b0);
        beat(300, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_rst_valid", int'(out_valid), 0);
        check("t5_rst_ready", int'(in_ready),  1);
        beat(7, 1'b1);
        check_result("t5", 7, 1, 0);
        take();

        // 33 terms: count saturates at 31
        for (int i = 0; i < 32; i++) beat(1, 1'b0);
        check("t6_mid_valid", int'(out_valid), 0);
        beat(1, 1'b1);
        check_result("t6", 33, 31, 0);
        take();
        check("t6_taken_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
